bcd_serial_adder_ctrl: RTL and testbench

Digit-serial controller that sequences one single-digit BCD adder across a DIGITS-wide packed-BCD operand pair. A start pulse captures both operands; the block then processes one digit per clock, least significant first, and rippples the decimal carry through a register. A one-cycle done pulse presents the registered result. It is the multi-digit front end for the existing 4-bit BCD digit adder, trading latency for a single adder instance.

---
 rtl/bcd_serial_adder_ctrl_pkg.sv | 18 +
 rtl/bcd_serial_adder_ctrl_bcd_adder.sv | 33 +++
 rtl/bcd_serial_adder_ctrl.sv | 154 +++++++++++++++
 tb/tb_bcd_serial_adder_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_serial_adder_ctrl_pkg.sv
// Shared definitions for the digit-serial BCD adder controller.
//   - state_t   : controller state encoding (IDLE, RUN, DONE)
//   - DIGIT_W   : width of one packed-BCD digit
//   - BCD_CORR  : decimal correction added when a digit sum exceeds BCD_MAX
//   - BCD_MAX   : largest legal decimal digit value
package bcd_serial_adder_ctrl_pkg;

    localparam int DIGIT_W  = 4;
    localparam int BCD_CORR = 6;
    localparam int BCD_MAX  = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_serial_adder_ctrl_bcd_adder.sv
// BCD_adder: single-digit decimal adder.
// Ports:
//   a, b  in  DIGIT_W  operand digits
//   cin   in  1        decimal carry-in
//   s     out DIGIT_W  result digit
//   cout  out 1        decimal carry-out
// Digits above 9 are not rejected; the result simply follows the same
// add / compare / correct formula.
module BCD_adder
    import bcd_serial_adder_ctrl_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] s,
    output logic               cout
);

    logic [DIGIT_W:0] z;

    always_comb begin
        z = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
        if (z > (DIGIT_W + 1)'(BCD_MAX)) begin
            // Adding 6 skips the six unused nibble codes; the wrap mod 16 is intended.
            s    = DIGIT_W'(z + (DIGIT_W + 1)'(BCD_CORR));
            cout = 1'b1;
        end else begin
            s    = z[DIGIT_W-1:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// bcd_serial_adder_ctrl: sequences one BCD_adder across DIGITS packed-BCD
// digits, least significant digit first, one digit per clock.
// Optional feature macro: BCD_SUB_EN (op=1 computes the ten's-complement
// difference A - B; when undefined op is ignored and no complement logic exists).
// Ports:
//   clk        in  rising-edge clock
//   reset_n    in  asynchronous active-low reset
//   start      in  request, sampled only in IDLE
//   a, b       in  4*DIGITS packed-BCD operands, digit 0 in [3:0]
//   cin        in  decimal carry-in to digit 0
//   op         in  0 = add, 1 = subtract (BCD_SUB_EN only)
//   busy       out high in RUN and DONE
//   done       out one-cycle completion pulse
//   sum        out registered result
//   cout       out registered decimal carry-out of the top digit
//   state_dbg  out current controller state (state_t encoding)
// Handshake: a request is accepted on the rising edge where start=1 and the
// block is IDLE (busy=0); a, b, cin and op are captured on that edge only.
// busy stays high until the edge after done; done is high for exactly one
// cycle and sum/cout are valid from then on until the next completion.
module bcd_serial_adder_ctrl
    import bcd_serial_adder_ctrl_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    input  logic                  op,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic [1:0]            state_dbg
);

    localparam int W  = DIGITS * DIGIT_W;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, work_q, work_d, sum_q, sum_d;
    logic            carry_q, carry_d, cout_q, cout_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [DIGIT_W-1:0] b_dig, dig_s;
    logic               dig_c, init_carry;

`ifdef BCD_SUB_EN
    logic op_q, op_d;
    // Nines complement of the B digit plus a forced initial carry gives A - B.
    assign b_dig      = op_q ? (DIGIT_W'(BCD_MAX) - b_q[DIGIT_W-1:0]) : b_q[DIGIT_W-1:0];
    assign init_carry = op ? 1'b1 : cin;
`else
    logic unused_op;
    assign unused_op  = op;
    assign b_dig      = b_q[DIGIT_W-1:0];
    assign init_carry = cin;
`endif

    BCD_adder u_digit (
        .a    (a_q[DIGIT_W-1:0]),
        .b    (b_dig),
        .cin  (carry_q),
        .s    (dig_s),
        .cout (dig_c)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef BCD_SUB_EN
        op_d    = op_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = init_carry;
                    cnt_d   = '0;
                    work_d  = '0;
`ifdef BCD_SUB_EN
                    op_d    = op;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT_W;
                b_d     = b_q >> DIGIT_W;
                // New digit enters at the top, so after DIGITS shifts digit 0 sits in [3:0].
                work_d  = {dig_s, work_q[W-1:DIGIT_W]};
                carry_d = dig_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = {dig_s, work_q[W-1:DIGIT_W]};
                    cout_d  = dig_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef BCD_SUB_EN
            op_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef BCD_SUB_EN
            op_q    <= op_d;
`endif
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
module tb_bcd_serial_adder_ctrl;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         op = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;
    logic [1:0]   state_dbg;

    bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op        (op),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout),
        .state_dbg (state_dbg)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [W:0] exp_q[$];
    logic [W:0] last_res = '0;
    logic [W:0] mon_exp;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint unsigned bcd2int(input logic [W-1:0] x);
        longint unsigned v = 0;
        for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + longint'(x[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [W-1:0] int2bcd(input longint unsigned v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [W:0] model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                         input logic ci, input logic oi);
        longint unsigned va = bcd2int(ai);
        longint unsigned vb = bcd2int(bi);
        longint unsigned lim = 1;
        longint unsigned s;
        for (int i = 0; i < DIGITS; i++) lim = lim * 10;
`ifdef BCD_SUB_EN
        if (oi) begin
            if (va >= vb) return {1'b1, int2bcd(va - vb)};
            else          return {1'b0, int2bcd(lim - (vb - va))};
        end
`else
        if (oi) begin end
`endif
        s = va + vb + longint'(ci);
        return {(s >= lim) ? 1'b1 : 1'b0, int2bcd(s % lim)};
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!reset_n) begin
            last_res = '0;
        end else if (done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 with result %h, required no pending result", {cout, sum});
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", {cout, sum}, mon_exp);
            end
            last_res = {cout, sum};
        end else begin
            check("hold", {cout, sum}, last_res);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic scramble_inputs();
        a   = rand_bcd();
        b   = rand_bcd();
        cin = 1'($urandom_range(0, 1));
        op  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", busy, 0);
    endtask

    // Counts edges from the accepting edge until done is seen; inputs are
    // scrambled meanwhile, so the result must reflect the captured values.
    task automatic wait_done(input string name);
        int n = 0;
        bit seen = 0;
        while (!seen && n < 4 * DIGITS + 10) begin
            @(negedge clk);
            scramble_inputs();
            @(posedge clk);
            #1;
            n++;
            seen = done;
        end
        check({name, "_latency"}, (W+1)'(n), (W+1)'(DIGITS));
    endtask

    task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                         input logic oi, input logic [W:0] exp, input string name);
        wait_idle();
        a = ai; b = bi; cin = ci; op = oi;
        start = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        check({name, "_busy"}, busy, 1);
        start = 1'b0;
        wait_done(name);
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        logic [W-1:0] ra, rb;
        logic rc, ro;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        reset_n = 1'b1;

        do_op(16'h1234, 16'h5678, 1'b0, 1'b0, {1'b0, 16'h6912}, "add_basic");
        do_op(16'h9999, 16'h0001, 1'b0, 1'b0, {1'b1, 16'h0000}, "add_wrap");
        do_op(16'h0000, 16'h0000, 1'b1, 1'b0, {1'b0, 16'h0001}, "add_cin");
`ifdef BCD_SUB_EN
        do_op(16'h5000, 16'h1234, 1'b0, 1'b1, {1'b1, 16'h3766}, "sub_pos");
        do_op(16'h1234, 16'h5000, 1'b1, 1'b1, {1'b0, 16'h6234}, "sub_neg");
`endif

        // start held high through RUN and DONE: second accept only in IDLE
        wait_idle();
        ra = rand_bcd(); rb = rand_bcd(); rc = 1'($urandom_range(0, 1)); ro = 1'($urandom_range(0, 1));
        a = ra; b = rb; cin = rc; op = ro;
        start = 1'b1;
        exp_q.push_back(model(ra, rb, rc, ro));
        @(posedge clk);
        for (int i = 0; i < DIGITS + 1; i++) begin
            @(negedge clk);
            scramble_inputs();
        end
        @(negedge clk);
        check("held_idle", busy, 0);
        ra = rand_bcd(); rb = rand_bcd(); rc = 1'($urandom_range(0, 1)); ro = 1'($urandom_range(0, 1));
        a = ra; b = rb; cin = rc; op = ro;
        exp_q.push_back(model(ra, rb, rc, ro));
        @(posedge clk);
        #1;
        check("held_busy", busy, 1);
        start = 1'b0;
        wait_done("held2");

        // reset two cycles after accept discards the operation
        wait_idle();
        a = 16'h4321; b = 16'h1111; cin = 1'b0; op = 1'b0;
        start = 1'b1;
        exp_q.push_back(model(16'h4321, 16'h1111, 1'b0, 1'b0));
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_sum", sum, 0);
        check("midrst_cout", cout, 0);
        void'(exp_q.pop_back());
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (DIGITS + 3) @(negedge clk);
        do_op(16'h0808, 16'h0303, 1'b1, 1'b0, model(16'h0808, 16'h0303, 1'b1, 1'b0), "post_rst");

        // randomized operations
        for (int i = 0; i < 40; i++) begin
            ra = rand_bcd(); rb = rand_bcd(); rc = 1'($urandom_range(0, 1)); ro = 1'($urandom_range(0, 1));
            do_op(ra, rb, rc, ro, model(ra, rb, rc, ro), "rand");
        end

        repeat (3) @(negedge clk);
        check("queue_empty", (W+1)'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
